fpadd_result_stage: RTL and testbench
=====================================

Name: fpadd_result_stage

Overview:
- Registered result stage directly downstream of the DW_fp_addsub wrapper.
- Captures each combinational sum/difference and its 8-bit status word behind a valid/ready handshake.
- Buffers results in a 2-entry skid buffer so downstream backpressure never drops or reorders results.
- Accrues sticky IEEE exception flags and counts delivered results for the FP unit's CSR-style readout.

Parameters:
- sig_width, 23, significand width; matches the adder.
- exp_width, 8, exponent width; matches the adder.
- cnt_width, 16, width of the result counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  adder output (in_z/in_status) is valid this cycle.
- in_ready  output  1  stage can accept a result this cycle.
- in_z  input  sig_width+exp_width+1  adder result z.
- in_status  input  8  adder status.
- out_valid  output  1  out_z/out_status hold a result.
- out_ready  input  1  downstream accepts the result.
- out_z  output  sig_width+exp_width+1  registered result.
- out_status  output  8  registered status.
- clr_flags  input  1  clear sticky flags (one-cycle pulse).
- fflags  output  5  sticky flags {NV,DZ,OF,UF,NX}.
- result_cnt  output  cnt_width  number of results accepted at the input.

Behaviour:
- Reset is asynchronous and active-high, applied on the reset input. While reset is asserted:
  - out_valid=0, in_ready=1.
  - out_z=0, out_status=0.
  - fflags=0, result_cnt=0.
  - Both buffer entries are invalidated.
- Handshakes: input accept = in_valid & in_ready; output transfer = out_valid & out_ready.
- Latency: a result accepted in cycle N appears on out_z/out_status with out_valid=1 in cycle N+1.
- in_ready is registered: in_ready = !skid_valid, so there is no combinational path from out_ready.
- State machine:
  - EMPTY: nothing held.
    - Accept → ONE, result loaded into the output register.
  - ONE: output register valid.
    - Accept and transfer → stay ONE, new result loaded into the output register.
    - Accept and no transfer → FULL, new result loaded into the skid register.
    - Transfer and no accept → EMPTY.
    - Neither → hold.
  - FULL: output and skid registers valid; in_ready=0.
    - Transfer → ONE, skid moves to the output register.
    - No transfer → hold.
- Output stability: while out_valid=1 and out_ready=0, out_z/out_status must not change. Results leave in acceptance order.
- in_valid while in_ready=0 is ignored. Upstream must hold its data until it is accepted.
- Flag mapping from in_status, applied on input accept, not on output transfer:
  - NV |= status[2] (invalid).
  - OF |= status[4] (huge).
  - UF |= status[3] (tiny).
  - NX |= status[5] (inexact).
  - DZ is never set by this stage and stays 0.
- Simultaneous clr_flags and accept: fflags = the flags of the accepted result only. Clear applies first, then accrue.
- clr_flags with no accept: fflags = 0 the next cycle.
- result_cnt increments by 1 on each input accept and wraps from all-ones to 0.
- Reset mid-operation: any held results are discarded and are not delivered after reset deasserts.
- in_ready=1 in the first cycle after reset.
- status bits [1:0], [7:6] pass through to out_status but do not affect fflags.

Decomposition:
- Package fpadd_pkg:
  - Status bit index constants: ST_ZERO=0, ST_INF=1, ST_INVALID=2, ST_TINY=3, ST_HUGE=4, ST_INEXACT=5.
  - fflags index constants: NX=0, UF=1, OF=2, DZ=3, NV=4.
  - Buffer state enum {EMPTY, ONE, FULL}.
- Sub-module fpadd_skid_buf: the generic 2-entry valid/ready skid buffer, data width parameter.
- Flag accrual and the counter stay in the top module.

Test Plan:
- Single result:
  - Stimulus: in_z=0x40400000 (1.0+2.0), in_status=0x00, accepted at cycle N; out_ready=1.
  - Response: out_valid=1 with out_z=0x40400000 at cycle N+1; fflags=0; result_cnt=1.
- Backpressure ordering:
  - Stimulus: out_ready=0; offer 0x3F800000, 0x40000000, 0x40400000 on consecutive cycles.
  - Response: first two accepted; in_ready=0 from the cycle after the second accept; third held upstream.
  - Then raise out_ready: outputs are 0x3F800000, 0x40000000, 0x40400000 in order, with no loss or duplication.
- Flag accrual:
  - Stimulus: results with status 0x04, then 0x20, then 0x10.
  - Response: fflags=0x10, then 0x11, then 0x15.
- Clear/accrue collision:
  - Stimulus: fflags=0x15; assert clr_flags in the same cycle as accepting status 0x08.
  - Response: fflags=0x02 next cycle.
- Reset mid-operation:
  - Stimulus: in FULL state, assert reset asynchronously between clock edges.
  - Response: out_valid=0, in_ready=1, fflags=0, result_cnt=0 immediately; no stale result appears after release.
- Counter wrap:
  - Stimulus: cnt_width=4; accept 17 results.
  - Response: result_cnt reads 1.

Source files
------------

// File: rtl/fpadd_pkg.sv
// Shared constants for the FP adder result stage: adder status bit positions,
// accrued-exception flag positions and the result buffer occupancy states.
package fpadd_pkg;

   localparam int ST_ZERO    = 0;
   localparam int ST_INF     = 1;
   localparam int ST_INVALID = 2;
   localparam int ST_TINY    = 3;
   localparam int ST_HUGE    = 4;
   localparam int ST_INEXACT = 5;

   localparam int NX = 0;
   localparam int UF = 1;
   localparam int OF = 2;
   localparam int DZ = 3;
   localparam int NV = 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/fpadd_result_stage_if.sv
// Result bus between the DW_fp_addsub wrapper, this stage and its consumer.
interface fpadd_result_stage_if #(
   parameter int sig_width = 23,
   parameter int exp_width = 8
);
   localparam int ZW = sig_width + exp_width + 1;

   // A beat moves on a side only in a cycle where its valid and ready are both 1;
   // the sender holds valid and data steady until that happens.
   logic          in_valid;
   logic          in_ready;
   logic [ZW-1:0] in_z;
   logic [7:0]    in_status;
   logic          out_valid;
   logic          out_ready;
   logic [ZW-1:0] out_z;
   logic [7:0]    out_status;

   modport master (
      output in_valid, in_z, in_status, out_ready,
      input  in_ready, out_valid, out_z, out_status
   );

   modport slave (
      input  in_valid, in_z, in_status, out_ready,
      output in_ready, out_valid, out_z, out_status
   );

endinterface

// File: rtl/fpadd_skid_buf.sv
// Two-entry valid/ready skid buffer: an output register plus one skid register,
// so in_ready_o depends only on local state and never on out_ready_i.
module fpadd_skid_buf
   import fpadd_pkg::*;
#(
   parameter int width = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [width-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [width-1:0] out_data_o,
   output buf_state_e       state_o
);

   buf_state_e       state_q, state_d;
   logic [width-1:0] out_q, out_d;
   logic [width-1:0] skid_q, skid_d;
   logic             accept;
   logic             xfer;

   assign in_ready_o  = (state_q != FULL);
   assign out_valid_o = (state_q != EMPTY);
   assign out_data_o  = out_q;
   assign state_o     = state_q;
   assign accept      = in_valid_i & in_ready_o;
   assign xfer        = out_valid_o & out_ready_i;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               out_d   = in_data_i;
            end
         end
         ONE: begin
            if (accept && xfer) begin
               out_d = in_data_i;
            end else if (accept) begin
               state_d = FULL;
               skid_d  = in_data_i;
            end else if (xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // The older result sits in out_q, so the skid entry only ever moves forward.
            if (xfer) begin
               state_d = ONE;
               out_d   = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/fpadd_result_stage.sv
// Registered result stage behind the FP adder: buffers sum/status pairs, accrues
// sticky IEEE flags and counts accepted results for CSR readout.
module fpadd_result_stage
   import fpadd_pkg::*;
#(
   parameter int sig_width = 23,
   parameter int exp_width = 8,
   parameter int cnt_width = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   fpadd_result_stage_if.slave   bus,
   input  logic                  clr_flags,
   output logic [4:0]            fflags,
   output logic [cnt_width-1:0]  result_cnt,
   output buf_state_e            dbg_state
);

   localparam int ZW = sig_width + exp_width + 1;

   logic [ZW+7:0]        out_data;
   logic                 accept;
   logic [4:0]           flag_set;
   logic [4:0]           fflags_q, fflags_d;
   logic [cnt_width-1:0] cnt_q, cnt_d;

   fpadd_skid_buf #(.width(ZW + 8)) u_skid (
      .clk         (clk),
      .rst         (reset),
      .in_valid_i  (bus.in_valid),
      .in_ready_o  (bus.in_ready),
      .in_data_i   ({bus.in_status, bus.in_z}),
      .out_valid_o (bus.out_valid),
      .out_ready_i (bus.out_ready),
      .out_data_o  (out_data),
      .state_o     (dbg_state)
   );

   assign bus.out_z      = out_data[ZW-1:0];
   assign bus.out_status = out_data[ZW+7:ZW];
   assign accept         = bus.in_valid & bus.in_ready;
   assign fflags         = fflags_q;
   assign result_cnt     = cnt_q;

   // Flags accrue at acceptance; a same-cycle clear wipes only the older history.
   always_comb begin
      flag_set             = '0;
      flag_set[NV]         = bus.in_status[ST_INVALID];
      flag_set[OF]         = bus.in_status[ST_HUGE];
      flag_set[UF]         = bus.in_status[ST_TINY];
      flag_set[NX]         = bus.in_status[ST_INEXACT];
      fflags_d             = clr_flags ? 5'b0 : fflags_q;
      if (accept) fflags_d = fflags_d | flag_set;
      cnt_d                = accept ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fflags_q <= '0;
         cnt_q    <= '0;
      end else begin
         fflags_q <= fflags_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fpadd_result_stage.sv
// Directed bench for fpadd_result_stage: driver tasks push expected results into a
// queue, and an independent monitor pops and compares every delivered result.
module tb_fpadd_result_stage;
   import fpadd_pkg::*;

   logic        clk;
   logic        reset;
   logic        clr_flags;
   logic [4:0]  fflags;
   logic [3:0]  result_cnt;
   buf_state_e  dbg_state;

   fpadd_result_stage_if bus ();

   fpadd_result_stage #(.cnt_width(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .clr_flags  (clr_flags),
      .fflags     (fflags),
      .result_cnt (result_cnt),
      .dbg_state  (dbg_state)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [39:0] exp_q[$];
   logic [3:0]  exp_cnt = '0;
   logic [39:0] hold_v;
   bit          have_hold = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // driver: holds the offer until the bench sees in_ready at an edge
   task automatic send(input logic [31:0] z, input logic [7:0] st, input logic clr);
      int   waited;
      logic rdy;
      waited        = 0;
      bus.in_valid  = 1'b1;
      bus.in_z      = z;
      bus.in_status = st;
      clr_flags     = clr;
      do begin
         rdy = bus.in_ready;
         step();
         waited++;
      end while (!rdy && waited < 50);
      if (!rdy) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: z=0x%0h never accepted within %0d cycles", z, waited);
      end else begin
         exp_q.push_back({st, z});
         exp_cnt++;
      end
      bus.in_valid = 1'b0;
      clr_flags    = 1'b0;
   endtask

   // scoreboard monitor: negedge sampling sees what the next rising edge transfers
   always @(negedge clk) begin
      if (reset) begin
         have_hold = 0;
      end else begin
         if (have_hold && bus.out_valid)
            check("out_stable", {bus.out_status, bus.out_z}, hold_v);
         if (bus.out_valid && bus.out_ready) begin
            have_hold = 0;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_out: got 0x%0h, expected no result", {bus.out_status, bus.out_z});
            end else begin
               check("out_result", {bus.out_status, bus.out_z}, exp_q.pop_front());
            end
         end else if (bus.out_valid) begin
            have_hold = 1;
            hold_v    = {bus.out_status, bus.out_z};
         end else begin
            have_hold = 0;
         end
      end
   end

   initial begin
      reset         = 1'b1;
      clr_flags     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_z      = '0;
      bus.in_status = '0;
      bus.out_ready = 1'b0;

      // reset state
      step();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_z", bus.out_z, 0);
      check("rst_out_status", bus.out_status, 0);
      check("rst_fflags", fflags, 0);
      check("rst_cnt", result_cnt, 0);
      step();
      reset = 1'b0;
      step();
      check("first_in_ready", bus.in_ready, 1);

      // single result, visible the cycle after acceptance
      bus.out_ready = 1'b1;
      send(32'h4040_0000, 8'h00, 1'b0);
      check("single_out_valid", bus.out_valid, 1);
      check("single_out_z", bus.out_z, 32'h4040_0000);
      check("single_fflags", fflags, 0);
      check("single_cnt", result_cnt, 1);
      step();

      // backpressure: two accepted, third held upstream, order preserved
      bus.out_ready = 1'b0;
      send(32'h3F80_0000, 8'h00, 1'b0);
      send(32'h4000_0000, 8'h00, 1'b0);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_state", dbg_state, FULL);
      bus.in_valid  = 1'b1;
      bus.in_z      = 32'h4040_0000;
      bus.in_status = 8'h00;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_ready", bus.in_ready, 0);
         check("bp_hold_cnt", result_cnt, exp_cnt);
      end
      bus.out_ready = 1'b1;
      send(32'h4040_0000, 8'h00, 1'b0);
      repeat (3) step();
      check("bp_drained", exp_q.size(), 0);

      // flag accrual: NV, then NX, then OF
      send(32'h7FC0_0000, 8'h04, 1'b0);
      check("flag_nv", fflags, 5'h10);
      send(32'h3EAA_AAAB, 8'h20, 1'b0);
      check("flag_nx", fflags, 5'h11);
      send(32'h7F80_0000, 8'h10, 1'b0);
      check("flag_of", fflags, 5'h15);

      // clear colliding with an accept keeps only the new result's flags
      send(32'h0000_0001, 8'h08, 1'b1);
      check("clr_collide", fflags, 5'h02);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("clr_only", fflags, 5'h00);

      // status bits outside the flag mapping pass through without accruing
      send(32'h7F80_0000, 8'hC3, 1'b0);
      check("passthru_fflags", fflags, 5'h00);
      repeat (2) step();

      // asynchronous reset while FULL discards both held results
      bus.out_ready = 1'b0;
      send(32'h4110_0000, 8'h20, 1'b0);
      send(32'h4120_0000, 8'h04, 1'b0);
      check("mid_state_full", dbg_state, FULL);
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      check("mid_rst_fflags", fflags, 0);
      check("mid_rst_cnt", result_cnt, 0);
      step();
      reset   = 1'b0;
      exp_cnt = '0;
      bus.out_ready = 1'b1;
      check("post_rst_in_ready", bus.in_ready, 1);
      repeat (4) step();
      check("post_rst_no_out", bus.out_valid, 0);

      // 4-bit counter wraps after 16 accepts
      for (int i = 0; i < 17; i++) send(32'h3F80_0000 + i, 8'h00, 1'b0);
      check("cnt_wrap", result_cnt, 4'd1);
      check("cnt_model", result_cnt, exp_cnt);

      repeat (3) step();
      check("final_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
